// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic skid-buffer pipeline.
package pipe_pkg;

    // Occupancy of one stage: nothing, main register only, main plus skid register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_st_t;

    localparam int STALL_CNT_W = 16;

    // Saturating increment for the stall counter: sticks at all-ones.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] val);
        logic [STALL_CNT_W-1:0] res;
        if (val == {STALL_CNT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One elastic stage: a main register presented downstream and a skid register
// that absorbs the single word arriving in the cycle the downstream side stalls.
// Both up_ready and dn_valid are flops, so no handshake path crosses the stage.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    skid_st_t         state_r;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] skid_r;
    logic             valid_r;
    logic             ready_r;
    logic             up_fire_s;
    logic             dn_fire_s;

    assign up_fire_s = up_valid & ready_r;
    assign dn_fire_s = valid_r & dn_ready;

    assign up_ready = ready_r;
    assign dn_valid = valid_r;
    assign dn_data  = main_r;

    // Stage FSM with its data registers; valid/ready flops track the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_EMPTY;
            main_r  <= {WIDTH{1'b0}};
            skid_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else if (flush) begin
            // Data registers keep their contents; only occupancy is cleared.
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (up_fire_s) begin
                        state_r <= ST_BUSY;
                        main_r  <= up_data;
                        valid_r <= 1'b1;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_EMPTY;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (up_fire_s && dn_fire_s) begin
                        state_r <= ST_BUSY;
                        main_r  <= up_data;
                        valid_r <= 1'b1;
                        ready_r <= 1'b1;
                    end else if (up_fire_s) begin
                        // Downstream stalled: park the new word in the skid register.
                        state_r <= ST_FULL;
                        skid_r  <= up_data;
                        valid_r <= 1'b1;
                        ready_r <= 1'b0;
                    end else if (dn_fire_s) begin
                        state_r <= ST_EMPTY;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_BUSY;
                        valid_r <= 1'b1;
                        ready_r <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (dn_fire_s) begin
                        state_r <= ST_BUSY;
                        main_r  <= skid_r;
                        valid_r <= 1'b1;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_FULL;
                        valid_r <= 1'b1;
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_skid_chain.sv
// Elastic pipeline register: DEPTH chained skid stages of WIDTH bits.
// Optional feature macro: PIPE_STALL_CNT_EN builds a saturating counter of
// cycles where upstream offers data but the chain refuses it; without the
// macro stall_cnt is tied to zero and no counter logic exists.
module pipe_skid_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_skid_chain: DEPTH must be at least 1");
    end

    // Index k is the interface entering stage k; index DEPTH is the chain output.
    logic [DEPTH:0]            valid_s;
    logic [DEPTH:0]            ready_s;
    logic [DEPTH:0][WIDTH-1:0] data_s;

    assign valid_s[0]     = in_valid;
    assign data_s[0]      = in_data;
    assign ready_s[DEPTH] = out_ready;

    assign in_ready  = ready_s[0];
    assign out_valid = valid_s[DEPTH];
    assign out_data  = data_s[DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_skid_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .up_valid (valid_s[k]),
            .up_ready (ready_s[k]),
            .up_data  (data_s[k]),
            .dn_valid (valid_s[k+1]),
            .dn_ready (ready_s[k+1]),
            .dn_data  (data_s[k+1])
        );
    end

`ifdef PIPE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    // Count refused input offers; flush leaves the count alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (in_valid && !ready_s[0]) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = {STALL_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_skid_chain.sv
// Bench for pipe_skid_chain: a DEPTH=2 instance carries every check, and a
// DEPTH=3 instance on the same inputs is checked in the streaming test.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pipe_skid_chain;

    localparam int W  = 8;
    localparam int D2 = 2;
    localparam int D3 = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [15:0]  stall_cnt;

    logic         in_ready3;
    logic         out_valid3;
    logic [W-1:0] out_data3;
    logic [15:0]  stall_cnt3;

    int vectors = 0;
    int errors  = 0;

`ifdef PIPE_STALL_CNT_EN
    localparam logic [15:0] EXP_STALL20 = 16'd20;
`else
    localparam logic [15:0] EXP_STALL20 = 16'd0;
`endif

    always #5 clk = ~clk;

    pipe_skid_chain #(.WIDTH(W), .DEPTH(D2)) u_dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_skid_chain #(.WIDTH(W), .DEPTH(D3)) u_dut3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
        .stall_cnt(stall_cnt3)
    );

    typedef struct packed {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         fl;
        logic         e_ir;
        logic         e_ov;
        logic [W-1:0] e_od;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [W-1:0] d, logic ordy, logic fl,
                                logic e_ir, logic e_ov, logic [W-1:0] e_od);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Two reset cycles then one idle cycle; leaves the bench on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] q[$];
        logic [W-1:0] prev_data;
        logic         hold_prev;
        logic         after_flush;
        logic         fl;
        logic         dv;
        int           accepted;
        logic [W-1:0] exp_d;

        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data",  out_data, 8'h00);
        chk("rst_in_ready",  in_ready, 1'b1);
        chk("rst_stall_cnt", stall_cnt, 16'h0000);
        chk("rst_in_ready_d3", in_ready3, 1'b1);

        // ---------------- table: backpressure, drain, flush ----------------
        // {in_valid, in_data, out_ready, flush, exp in_ready, exp out_valid, exp out_data}
        tbl.push_back(mk(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01));
        tbl.push_back(mk(1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01));
        tbl.push_back(mk(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01));
        tbl.push_back(mk(1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01));
        tbl.push_back(mk(1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02));
        tbl.push_back(mk(1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0));
        tbl.push_back(mk(1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0));
        tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00));

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
            end
            @(negedge clk);
        end

        // ---------------- streaming 0x01..0x10, both depths ----------------
        do_reset();
        for (int t = 0; t < 16 + D3 + 1; t++) begin
            drive(t < 16, W'(t + 1), 1'b1, 1'b0);
            if (t < 16) begin
                chk("stream_in_ready_d2", in_ready, 1'b1);
                chk("stream_in_ready_d3", in_ready3, 1'b1);
            end
            dv = (t >= D2) && (t - D2 < 16);
            chk("stream_out_valid_d2", out_valid, dv);
            if (dv) chk("stream_out_data_d2", out_data, W'(t - D2 + 1));
            dv = (t >= D3) && (t - D3 < 16);
            chk("stream_out_valid_d3", out_valid3, dv);
            if (dv) chk("stream_out_data_d3", out_data3, W'(t - D3 + 1));
            @(negedge clk);
        end

        // ---------------- stall counter ----------------
        do_reset();
        for (int t = 0; t < 4; t++) begin
            drive(1'b1, W'(8'hC0 + t), 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("cnt_full_in_ready", in_ready, 1'b0);
        repeat (20) @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("cnt_after_20", stall_cnt, EXP_STALL20);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("cnt_after_flush", stall_cnt, EXP_STALL20);
        chk("cnt_flush_out_valid", out_valid, 1'b0);
`ifdef PIPE_STALL_CNT_EN
        for (int t = 0; t < 4; t++) begin
            drive(1'b1, W'(t), 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        repeat (65540) @(negedge clk);
        chk("cnt_saturated", stall_cnt, 16'hFFFF);
        @(negedge clk);
        chk("cnt_saturated_hold", stall_cnt, 16'hFFFF);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
`endif

        // ---------------- randomized scoreboard ----------------
        do_reset();
        q.delete();
        accepted    = 0;
        hold_prev   = 1'b0;
        after_flush = 1'b0;
        prev_data   = 8'h00;
        for (int c = 0; c < 40000 && !(accepted >= 3000 && q.size() == 0); c++) begin
            if (accepted >= 3000) begin
                drive(1'b0, 8'h00, 1'b1, 1'b0);
            end else begin
                fl = ($urandom_range(0, 199) == 0);
                drive(1'(($urandom_range(0, 1))), W'($urandom), 1'(($urandom_range(0, 1))), fl);
            end
            if (hold_prev) begin
                chk("rnd_hold_valid", out_valid, 1'b1);
                chk("rnd_hold_data", out_data, prev_data);
            end
            if (after_flush) begin
                chk("rnd_flush_out_valid", out_valid, 1'b0);
                chk("rnd_flush_in_ready", in_ready, 1'b1);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("rnd_spurious_out", out_valid, 1'b0);
                    end else begin
                        exp_d = q.pop_front();
                        chk("rnd_order", out_data, exp_d);
                    end
                end
                if (in_valid && in_ready) begin
                    q.push_back(in_data);
                    accepted++;
                end
                if (q.size() > 2 * D2) chk("rnd_capacity", q.size(), 2 * D2);
            end
            hold_prev   = !flush && out_valid && !out_ready;
            prev_data   = out_data;
            after_flush = flush;
            @(negedge clk);
        end
        chk("rnd_accepted", (accepted >= 3000), 1'b1);
        chk("rnd_drained", q.size(), 0);
        chk("rnd_final_out_valid", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
